// File: rtl/cacheline_adaptor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cacheline_adaptor                                                |
// | Purpose : 256-bit cacheline <-> four 64-bit memory bursts, with optional   |
// |           stall watchdog (define CACHELINE_ADAPTOR_WATCHDOG_EN)            |
// | Rev     : 1.1                                                              |
// +----------------------------------------------------------------------------+
module cacheline_adaptor #(
    parameter int BEATS   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [64*BEATS-1:0]   line_i,
    output logic [64*BEATS-1:0]   line_o,
    input  logic [31:0]           address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    output logic                  resp_o,
    output logic                  err_o,
    input  logic [63:0]           burst_i,
    output logic [63:0]           burst_o,
    output logic [31:0]           address_o,
    output logic                  read_o,
    output logic                  write_o,
    input  logic                  resp_i
);

    localparam int             CW       = $clog2(BEATS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            r_state, w_state_d;
    logic [CW-1:0]         r_cnt, w_cnt_d;
    logic [64*BEATS-1:0]   r_line, w_line_d;
    logic [64*BEATS-1:0]   r_wbuf, w_wbuf_d;
    logic [31:0]           r_addr, w_addr_d;
    logic                  r_err, w_err_d;
    logic                  w_busy;
    logic                  w_timeout;
    logic                  w_unused_addr_lsb;

    assign w_busy            = (r_state == READ) || (r_state == WRITE);
    assign w_unused_addr_lsb = ^address_i[4:0];

`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

    logic [9:0] r_wd, w_wd_d;

    always_comb begin
        w_wd_d = '0;
        if (w_busy && !resp_i) begin
            w_wd_d = r_wd + 10'd1;
        end
    end

    assign w_timeout = w_busy && !resp_i && (r_wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd <= '0;
        end else begin
            r_wd <= w_wd_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_line_d  = r_line;
        w_wbuf_d  = r_wbuf;
        w_addr_d  = r_addr;
        w_err_d   = 1'b0;
        case (r_state)
            IDLE: begin
                if (read_i) begin
                    w_addr_d  = {address_i[31:5], 5'b0};
                    w_cnt_d   = '0;
                    w_state_d = READ;
                end else if (write_i) begin
                    w_addr_d  = {address_i[31:5], 5'b0};
                    w_wbuf_d  = line_i;
                    w_cnt_d   = '0;
                    w_state_d = WRITE;
                end
            end
            READ: begin
                if (resp_i) begin
                    w_line_d[64*r_cnt +: 64] = burst_i;
                    w_cnt_d                  = r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_d = DONE;
                    end
                end else if (w_timeout) begin
                    w_err_d   = 1'b1;
                    w_state_d = DONE;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    w_cnt_d = r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_d = DONE;
                    end
                end else if (w_timeout) begin
                    w_err_d   = 1'b1;
                    w_state_d = DONE;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
            r_wbuf  <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_line  <= w_line_d;
            r_wbuf  <= w_wbuf_d;
            r_addr  <= w_addr_d;
            r_err   <= w_err_d;
        end
    end

    assign line_o    = r_line;
    assign address_o = r_addr;
    assign read_o    = (r_state == READ);
    assign write_o   = (r_state == WRITE);
    assign resp_o    = (r_state == DONE);
    assign err_o     = r_err;
    assign burst_o   = (r_state == WRITE) ? r_wbuf[64*r_cnt +: 64] : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// Self-checking bench for cacheline_adaptor: directed table, corner sequences,
// and randomized line transfers checked against a transaction-level model.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic         err_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int n_checks = 0;
    int n_pass   = 0;

    logic [255:0] model_line;

    always #5 clk = ~clk;

    cacheline_adaptor #(.BEATS(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i),
        .resp_o(resp_o), .err_o(err_o),
        .burst_i(burst_i), .burst_o(burst_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .resp_i(resp_i)
    );

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wline;
        logic [255:0] rline;
        logic [15:0]  gaps;      // nibble b = idle cycles before beat b
        logic [31:0]  exp_addr;
        logic [255:0] exp_line;
    } vec_t;

    vec_t vecs[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[32*i +: 32] = $urandom;
        end
        return l;
    endfunction

    // One full line transfer; request held until the completion pulse, inputs garbled after acceptance.
    task automatic do_txn(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [255:0] wline, input logic [255:0] rline,
                          input logic [15:0] gaps, input logic [31:0] exp_addr,
                          input logic [255:0] exp_line);
        logic [1:0] exp_req;
        exp_req   = rd ? 2'b10 : 2'b01;
        read_i    = rd;
        write_i   = wr;
        address_i = addr;
        line_i    = wline;
        resp_i    = 1'b0;
        step();
        address_i = $urandom;
        line_i    = rand_line();
        chk({tag, " req"}, {253'd0, read_o, write_o, resp_o}, {253'd0, exp_req, 1'b0});
        chk({tag, " address_o"}, {224'd0, address_o}, {224'd0, exp_addr});
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < int'(gaps[4*b +: 4]); g++) begin
                resp_i  = 1'b0;
                burst_i = {$urandom, $urandom};
                step();
                chk({tag, " wait"}, {253'd0, read_o, write_o, resp_o}, {253'd0, exp_req, 1'b0});
            end
            resp_i  = 1'b1;
            burst_i = rline[64*b +: 64];
            chk({tag, " beat"}, {253'd0, read_o, write_o, resp_o}, {253'd0, exp_req, 1'b0});
            if (!rd) begin
                chk({tag, " burst_o"}, {192'd0, burst_o}, {192'd0, wline[64*b +: 64]});
            end
            step();
        end
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        chk({tag, " done"}, {252'd0, read_o, write_o, resp_o, err_o}, {252'd0, 4'b0010});
        chk({tag, " line_o"}, line_o, exp_line);
        read_i  = 1'b0;
        write_i = 1'b0;
        step();
        chk({tag, " idle"}, {252'd0, read_o, write_o, resp_o, err_o}, 256'd0);
        chk({tag, " line_hold"}, line_o, exp_line);
    endtask

    initial begin
        logic [255:0] r2, r3, wl, junk;
        bit           rd, wr;
        logic [31:0]  addr;
        logic [255:0] wline, rline;
        logic [15:0]  gaps;

        r2   = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
        r3   = {64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE,
                64'hC3C3_3C3C_C3C3_3C3C, 64'h0000_0000_FFFF_FFFF};
        wl   = {64'hDDDD_0004_DDDD_0004, 64'hCCCC_0003_CCCC_0003,
                64'hBBBB_0002_BBBB_0002, 64'hAAAA_0001_AAAA_0001};
        junk = {4{64'hDEAD_BEEF_0BAD_F00D}};

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, junk,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    16'h0000, 32'h0000_1220,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_ABCD, wl, junk, 16'h2220, 32'h0000_ABC0,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vecs[2] = '{1'b1, 1'b1, 32'h8000_0047, wl, r2, 16'h0103, 32'h8000_0040, r2};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, junk, r3, 16'h0010, 32'hFFFF_FFE0, r3};

        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = '0; line_i = '0; burst_i = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset ctrl", {252'd0, read_o, write_o, resp_o, err_o}, 256'd0);
        chk("reset line_o", line_o, 256'd0);
        chk("reset address_o", {224'd0, address_o}, 256'd0);
        chk("reset burst_o", {192'd0, burst_o}, 256'd0);

        for (int i = 0; i < 4; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wline,
                   vecs[i].rline, vecs[i].gaps, vecs[i].exp_addr, vecs[i].exp_line);
        end
        model_line = r3;

        // Reset after two read beats discards the partial line.
        read_i = 1'b1; address_i = 32'h0000_2040;
        step();
        read_i = 1'b0;
        resp_i = 1'b1; burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
        step();
        burst_i = 64'hBBBB_BBBB_BBBB_BBBB;
        step();
        resp_i = 1'b0;
        chk("partial line_o", {128'd0, line_o[127:0]},
            {128'd0, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst ctrl", {252'd0, read_o, write_o, resp_o, err_o}, 256'd0);
        chk("midrst line_o", line_o, 256'd0);
        step();
        chk("midrst no resp", {255'd0, resp_o}, 256'd0);
        model_line = 256'd0;
        do_txn("post_rst", 1'b1, 1'b0, 32'h0000_2040, junk, r2, 16'h0000, 32'h0000_2040, r2);
        model_line = r2;

        for (int t = 0; t < 24; t++) begin
            rd    = 1'($urandom_range(0, 1));
            wr    = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            addr  = $urandom;
            wline = rand_line();
            rline = rand_line();
            for (int b = 0; b < 4; b++) begin
                gaps[4*b +: 4] = 4'($urandom_range(0, 6));
            end
            if (rd) model_line = rline;
            do_txn($sformatf("rand%0d", t), rd, wr, addr, wline, rline, gaps,
                   addr - (addr % 32), model_line);
        end

`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
        // Stalled read aborts with an error completion 9 cycles after the request edge.
        read_i = 1'b1; address_i = 32'h0000_3000; resp_i = 1'b0;
        step();
        read_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk("wd stall", {253'd0, read_o, resp_o, err_o}, {253'd0, 3'b100});
            step();
        end
        chk("wd abort", {253'd0, read_o, resp_o, err_o}, {253'd0, 3'b011});
        chk("wd line_hold", line_o, model_line);
        step();
        chk("wd idle", {252'd0, read_o, write_o, resp_o, err_o}, 256'd0);
`else
        // Without the watchdog a stalled read waits indefinitely, then completes normally.
        read_i = 1'b1; address_i = 32'h0000_3000; resp_i = 1'b0;
        step();
        read_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
        end
        chk("nowd stall", {253'd0, read_o, resp_o, err_o}, {253'd0, 3'b100});
        for (int b = 0; b < 4; b++) begin
            resp_i  = 1'b1;
            burst_i = r3[64*b +: 64];
            step();
        end
        resp_i = 1'b0;
        chk("nowd done", {253'd0, read_o, resp_o, err_o}, {253'd0, 3'b010});
        chk("nowd line_o", line_o, r3);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts single-beat 256-bit cacheline transfers from the cache datapath/controller into four 64-bit bursts on the physical-memory port, and reassembles read bursts into a full line. Sits directly downstream of the cache datapath: consumes `pmem_address`/`pmem_wdata` and produces `pmem_rdata` plus a completion response to the cache controller.

## Interface
- `BEATS`, 4, bursts per line; fixed, line width = 64*BEATS = 256
- `TIMEOUT`, 1023, watchdog limit in cycles; used only when the watchdog is compiled in
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — synchronous, active-high reset
- `line_i` in 256 — write line from cache (`pmem_wdata`)
- `line_o` out 256 — assembled read line (`pmem_rdata`)
- `address_i` in 32 — line address from cache (`pmem_address`)
- `read_i` in 1 — cache requests line fill
- `write_i` in 1 — cache requests line writeback
- `resp_o` out 1 — one-cycle completion pulse to cache
- `err_o` out 1 — completion was a watchdog abort; valid with `resp_o`
- `burst_i` in 64 — read beat from memory
- `burst_o` out 64 — write beat to memory
- `address_o` out 32 — latched line address, bits [4:0] forced 0
- `read_o` out 1 — memory read request
- `write_o` out 1 — memory write request
- `resp_i` in 1 — memory beat strobe

## Operation
- FSM states: IDLE, READ, WRITE, DONE; 2-bit beat counter `cnt`.
- IDLE: if `read_i`, latch `{address_i[31:5],5'b0}` into `address_o`, clear `cnt`, go READ. Else if `write_i`, latch address and `line_i` into write buffer, clear `cnt`, go WRITE. Both high: read wins, write ignored.
- READ: `read_o`=1. Each cycle with `resp_i`=1: `line_o[64*cnt +: 64] <= burst_i`, `cnt++`. On `resp_i` with `cnt`==3 go DONE.
- WRITE: `write_o`=1, `burst_o` = write buffer `[64*cnt +: 64]` combinationally. Each `resp_i`=1 cycle consumes current beat, `cnt++`. On `resp_i` with `cnt`==3 go DONE.
- `resp_i`=0 cycles inside READ/WRITE are wait states: no data movement, counter holds; gaps between beats are legal.
- DONE: `resp_o`=1 for exactly one cycle, `read_o`/`write_o`=0, go IDLE. `line_o` holds until the next READ overwrites beats.
- The cache drops `read_i`/`write_i` the cycle after `resp_o`; `read_i`/`write_i` are ignored outside IDLE. `line_i`/`address_i` changes after acceptance have no effect.
- `resp_i` in IDLE/DONE is ignored.

## Timing
- Reset values: state IDLE, `cnt`=0, `line_o`=0, write buffer=0, `address_o`=0, `read_o`=`write_o`=`resp_o`=`err_o`=0, `burst_o`=0.
- Request sampled at edge E: `read_o`/`write_o` high from cycle E+1.
- Final beat `resp_i` at cycle k: `read_o`/`write_o` low and `resp_o` high in cycle k+1; complete `line_o` valid in cycle k+1.
- Minimum turnaround: request in IDLE, four back-to-back beats, DONE: 6 cycles from request sample to IDLE.
- `rst` mid-transfer: next cycle IDLE, requests deasserted, partial line discarded (`line_o`=0), no `resp_o`.

## Configuration
- `CACHELINE_ADAPTOR_WATCHDOG_EN` defined: 10-bit idle counter cleared on entry to READ/WRITE and on every `resp_i`=1; increments on each READ/WRITE cycle with `resp_i`=0. On reaching `TIMEOUT`, go DONE with `err_o`=1 alongside `resp_o`; memory request dropped; `line_o` holds whatever beats arrived. `err_o` is 0 on normal completion.
- Not defined: no counter; `err_o` tied 0; READ/WRITE wait indefinitely.

## Test plan
- Reset: assert `rst` 2 cycles -> all outputs 0, FSM IDLE, `line_o`=0.
- Read: `read_i`, `address_i`=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> `address_o`=0x0000_1220, `resp_o` one cycle after 4th beat, `line_o`={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write: `write_i`, `line_i`={D,C,B,A}, `resp_i` pulsed with 2 idle cycles between beats -> `burst_o` A,B,C,D on successive `resp_i` cycles, `write_o` held throughout, single `resp_o`.
- Simultaneous `read_i`=`write_i`=1 -> READ performed, `write_o` never asserted.
- Reset after 2 read beats -> `read_o` low next cycle, `line_o`=0, no `resp_o`; a following read completes normally.
- Watchdog (macro on, `TIMEOUT`=8): read with no `resp_i` -> `resp_o`=`err_o`=1 exactly 9 cycles after request sample, `read_o` low; macro off -> `read_o` stays high, `err_o`=0.
